// File: rtl/pong_engine.sv
// Two-player pong core: internal game-tick divider, two paddles, one bouncing ball,
// scoring with serve/point delays and a terminal game-over state.
module pong_engine #(
    parameter int WIDTH      = 16,
    parameter int HEIGHT     = 16,
    parameter int CW         = 4,
    parameter int TICKDIV    = 12000,
    parameter int BALLDIV    = 20,
    parameter int PADDLEDIV  = 40,
    parameter int PADDLE     = 3,
    parameter int SERVEDELAY = 500,
    parameter int WINSCORE   = 9,
    parameter int SW         = 4
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          p1_up,
    input  logic          p1_down,
    input  logic          p2_up,
    input  logic          p2_down,
    input  logic          pause,
    output logic          tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic [CW-1:0] p1_pos,
    output logic [CW-1:0] p2_pos,
    output logic [SW-1:0] p1_score,
    output logic [SW-1:0] p2_score,
    output logic          game_over
);

    localparam int DIV_W  = (TICKDIV    > 1) ? $clog2(TICKDIV)    : 1;
    localparam int STEP_W = (BALLDIV    > 1) ? $clog2(BALLDIV)    : 1;
    localparam int PAD_W  = (PADDLEDIV  > 1) ? $clog2(PADDLEDIV)  : 1;
    localparam int SRV_W  = (SERVEDELAY > 1) ? $clog2(SERVEDELAY) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICKDIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BALLDIV - 1);
    localparam logic [PAD_W-1:0]  PAD_LAST  = PAD_W'(PADDLEDIV - 1);
    localparam logic [SRV_W-1:0]  SRV_LAST  = SRV_W'(SERVEDELAY - 1);

    localparam logic [CW-1:0] X_MID    = CW'(WIDTH / 2);
    localparam logic [CW-1:0] Y_MID    = CW'(HEIGHT / 2);
    localparam logic [CW-1:0] Y_LAST   = CW'(HEIGHT - 1);
    localparam logic [CW-1:0] X_GOAL2  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] X_FRONT2 = CW'(WIDTH - 2);
    localparam logic [CW-1:0] X_BACK2  = CW'(WIDTH - 3);
    localparam logic [CW-1:0] POS_LAST = CW'(HEIGHT - PADDLE);
    localparam logic [CW-1:0] POS_INIT = CW'((HEIGHT - PADDLE) / 2);
    localparam logic [SW-1:0] WIN      = SW'(WINSCORE);

    typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   div_cnt_reg;
    logic [STEP_W-1:0]  step_cnt_reg, step_cnt_next;
    logic [PAD_W-1:0]   pad_cnt_reg, pad_cnt_next;
    logic [SRV_W-1:0]   srv_cnt_reg, srv_cnt_next;
    logic [CW-1:0]      x_reg, x_next, y_reg, y_next;
    logic               dx_reg, dx_next, dy_reg, dy_next;   // 1 = +1, 0 = -1
    logic [SW-1:0]      s1_reg, s1_next, s2_reg, s2_next;
    logic               game_over_reg;

    logic               dy_eff;
    logic [CW-1:0]      ny;
    logic               p1_cover, p2_cover;
    logic               pad_move;
    logic [1:0]         btn_up, btn_down;

    assign tick     = (div_cnt_reg == DIV_LAST) && !pause;
    assign btn_up   = {p2_up, p1_up};
    assign btn_down = {p2_down, p1_down};
    assign pad_move = tick && (state_reg != OVER) && (pad_cnt_reg == PAD_LAST);

    // Vertical part of a ball step: reflect off the top/bottom rows before moving.
    assign dy_eff = (((y_reg == '0) && !dy_reg) || ((y_reg == Y_LAST) && dy_reg)) ? ~dy_reg : dy_reg;
    assign ny     = dy_eff ? y_reg + CW'(1) : y_reg - CW'(1);

    // Hit tests use the paddle positions held before this tick's paddle move.
    assign p1_cover = ({1'b0, ny} >= {1'b0, g_paddle[0].pos_reg}) &&
                      ({1'b0, ny} <= {1'b0, g_paddle[0].pos_reg} + (CW+1)'(PADDLE - 1));
    assign p2_cover = ({1'b0, ny} >= {1'b0, g_paddle[1].pos_reg}) &&
                      ({1'b0, ny} <= {1'b0, g_paddle[1].pos_reg} + (CW+1)'(PADDLE - 1));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_paddle
            logic [CW-1:0] pos_reg, pos_next;

            always_comb begin
                pos_next = pos_reg;
                if (pad_move) begin
                    if (btn_up[gi] && !btn_down[gi] && (pos_reg != '0))
                        pos_next = pos_reg - CW'(1);
                    else if (btn_down[gi] && !btn_up[gi] && (pos_reg != POS_LAST))
                        pos_next = pos_reg + CW'(1);
                end
            end

            always_ff @(posedge CLK) begin
                if (reset)
                    pos_reg <= POS_INIT;
                else
                    pos_reg <= pos_next;
            end
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        step_cnt_next = step_cnt_reg;
        pad_cnt_next  = pad_cnt_reg;
        srv_cnt_next  = srv_cnt_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        dx_next       = dx_reg;
        dy_next       = dy_reg;
        s1_next       = s1_reg;
        s2_next       = s2_reg;

        if (tick && (state_reg != OVER))
            pad_cnt_next = (pad_cnt_reg == PAD_LAST) ? '0 : pad_cnt_reg + PAD_W'(1);

        if (tick) begin
            case (state_reg)
                SERVE: begin
                    x_next  = X_MID;
                    y_next  = Y_MID;
                    dy_next = 1'b1;
                    if (srv_cnt_reg == SRV_LAST) begin
                        state_next    = PLAY;
                        srv_cnt_next  = '0;
                        step_cnt_next = '0;
                    end else begin
                        srv_cnt_next = srv_cnt_reg + SRV_W'(1);
                    end
                end
                PLAY: begin
                    if (step_cnt_reg != STEP_LAST) begin
                        step_cnt_next = step_cnt_reg + STEP_W'(1);
                    end else begin
                        step_cnt_next = '0;
                        y_next        = ny;
                        dy_next       = dy_eff;
                        // A miss leaves dx reversed, so the next serve goes the other way.
                        if ((x_reg == CW'(1)) && !dx_reg) begin
                            dx_next = 1'b1;
                            if (p1_cover) begin
                                x_next = CW'(2);
                            end else begin
                                x_next     = '0;
                                s2_next    = s2_reg + SW'(1);
                                state_next = POINT;
                            end
                        end else if ((x_reg == X_FRONT2) && dx_reg) begin
                            dx_next = 1'b0;
                            if (p2_cover) begin
                                x_next = X_BACK2;
                            end else begin
                                x_next     = X_GOAL2;
                                s1_next    = s1_reg + SW'(1);
                                state_next = POINT;
                            end
                        end else begin
                            x_next = dx_reg ? x_reg + CW'(1) : x_reg - CW'(1);
                        end
                    end
                end
                POINT: begin
                    if (srv_cnt_reg != SRV_LAST) begin
                        srv_cnt_next = srv_cnt_reg + SRV_W'(1);
                    end else begin
                        srv_cnt_next = '0;
                        if ((s1_reg == WIN) || (s2_reg == WIN)) begin
                            state_next = OVER;
                        end else begin
                            state_next = SERVE;
                            x_next     = X_MID;
                            y_next     = Y_MID;
                            dy_next    = 1'b1;
                        end
                    end
                end
                OVER: ;
                default: state_next = SERVE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            div_cnt_reg   <= '0;
            state_reg     <= SERVE;
            step_cnt_reg  <= '0;
            pad_cnt_reg   <= '0;
            srv_cnt_reg   <= '0;
            x_reg         <= X_MID;
            y_reg         <= Y_MID;
            dx_reg        <= 1'b1;
            dy_reg        <= 1'b1;
            s1_reg        <= '0;
            s2_reg        <= '0;
            game_over_reg <= 1'b0;
        end else begin
            if (!pause)
                div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_W'(1);
            state_reg     <= state_next;
            step_cnt_reg  <= step_cnt_next;
            pad_cnt_reg   <= pad_cnt_next;
            srv_cnt_reg   <= srv_cnt_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            dx_reg        <= dx_next;
            dy_reg        <= dy_next;
            s1_reg        <= s1_next;
            s2_reg        <= s2_next;
            game_over_reg <= (state_next == OVER);
        end
    end

    assign x         = x_reg;
    assign y         = y_reg;
    assign p1_pos    = g_paddle[0].pos_reg;
    assign p2_pos    = g_paddle[1].pos_reg;
    assign p1_score  = s1_reg;
    assign p2_score  = s2_reg;
    assign game_over = game_over_reg;

endmodule

// File: tb/tb_pong_engine.sv
// Self-checking bench for pong_engine: a cycle model feeds an expectation queue,
// plus fixed-value checkpoints along serve, hit, miss, game-over and pause scenarios.
module tb_pong_engine;

    localparam int WIDTH = 8, HEIGHT = 8, CW = 4, TICKDIV = 4, BALLDIV = 2;
    localparam int PADDLEDIV = 1, PADDLE = 3, SERVEDELAY = 2, WINSCORE = 2, SW = 4;
    localparam int S_SERVE = 0, S_PLAY = 1, S_POINT = 2, S_OVER = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0, pause = 1'b0;
    logic          tick, game_over;
    logic [CW-1:0] x, y, p1_pos, p2_pos;
    logic [SW-1:0] p1_score, p2_score;

    int n_pass = 0, n_total = 0, cyc = 0;
    logic [31:0] exp_q[$];

    int m_div, m_x, m_y, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2, m_st, m_srv, m_step, m_pad;

    pong_engine #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CW(CW), .TICKDIV(TICKDIV), .BALLDIV(BALLDIV),
        .PADDLEDIV(PADDLEDIV), .PADDLE(PADDLE), .SERVEDELAY(SERVEDELAY),
        .WINSCORE(WINSCORE), .SW(SW)
    ) dut (
        .CLK(clk), .reset(reset),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
        .pause(pause), .tick(tick), .x(x), .y(y), .p1_pos(p1_pos), .p2_pos(p2_pos),
        .p1_score(p1_score), .p2_score(p2_score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got === expv) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, expv);
    endtask

    function automatic logic [31:0] dut_pack();
        return {7'd0, x, y, p1_pos, p2_pos, p1_score, p2_score, game_over};
    endfunction

    function automatic logic [31:0] model_pack();
        return {7'd0, 4'(m_x), 4'(m_y), 4'(m_p1), 4'(m_p2), 4'(m_s1), 4'(m_s2),
                1'(m_st == S_OVER)};
    endfunction

    function automatic bit model_tick();
        return (m_div == TICKDIV - 1) && !pause;
    endfunction

    function automatic int paddle_move(input int p, input logic u, input logic d);
        if (u && !d && p > 0) return p - 1;
        if (d && !u && p < HEIGHT - PADDLE) return p + 1;
        return p;
    endfunction

    task automatic model_reset();
        m_div = 0; m_x = WIDTH / 2; m_y = HEIGHT / 2; m_dx = 1; m_dy = 1;
        m_p1 = (HEIGHT - PADDLE) / 2; m_p2 = (HEIGHT - PADDLE) / 2;
        m_s1 = 0; m_s2 = 0; m_st = S_SERVE; m_srv = 0; m_step = 0; m_pad = 0;
    endtask

    // Advance the model by one clock edge with the inputs currently driven.
    task automatic model_clock();
        int  ny, old_st;
        bit  t;
        if (reset) begin
            model_reset();
            return;
        end
        t = model_tick();
        if (!pause) m_div = (m_div + 1) % TICKDIV;
        if (!t) return;
        old_st = m_st;
        case (m_st)
            S_SERVE: begin
                if (m_srv == SERVEDELAY - 1) begin
                    m_st = S_PLAY; m_srv = 0; m_step = 0;
                end else m_srv++;
            end
            S_PLAY: begin
                if (m_step < BALLDIV - 1) m_step++;
                else begin
                    m_step = 0;
                    if ((m_y == 0 && m_dy < 0) || (m_y == HEIGHT - 1 && m_dy > 0)) m_dy = -m_dy;
                    ny = m_y + m_dy;
                    if (m_x == 1 && m_dx < 0) begin
                        m_dx = 1;
                        if (ny >= m_p1 && ny < m_p1 + PADDLE) m_x = 2;
                        else begin m_x = 0; m_s2++; m_st = S_POINT; end
                    end else if (m_x == WIDTH - 2 && m_dx > 0) begin
                        m_dx = -1;
                        if (ny >= m_p2 && ny < m_p2 + PADDLE) m_x = WIDTH - 3;
                        else begin m_x = WIDTH - 1; m_s1++; m_st = S_POINT; end
                    end else m_x = m_x + m_dx;
                    m_y = ny;
                end
            end
            S_POINT: begin
                if (m_srv < SERVEDELAY - 1) m_srv++;
                else begin
                    m_srv = 0;
                    if (m_s1 == WINSCORE || m_s2 == WINSCORE) m_st = S_OVER;
                    else begin m_st = S_SERVE; m_x = WIDTH / 2; m_y = HEIGHT / 2; m_dy = 1; end
                end
            end
            default: ;
        endcase
        if (old_st != S_OVER) begin
            if (m_pad == PADDLEDIV - 1) begin
                m_pad = 0;
                m_p1 = paddle_move(m_p1, p1_up, p1_down);
                m_p2 = paddle_move(m_p2, p2_up, p2_down);
            end else m_pad++;
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic run_cycle();
        logic [31:0] e;
        #1;
        if (!reset) check("tick", 32'(tick), 32'(model_tick()));
        model_clock();
        exp_q.push_back(model_pack());
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("outs", dut_pack(), e);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) run_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run_cycle();
        run_cycle();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic expect_state(input string tag, input int ex, input int ey, input int ep1,
                                input int ep2, input int es1, input int es2, input int ego);
        check(tag, dut_pack(), {7'd0, 4'(ex), 4'(ey), 4'(ep1), 4'(ep2), 4'(es1), 4'(es2), 1'(ego)});
        $display("%-12s cyc=%0d ball=(%0d,%0d) pads=%0d/%0d score=%0d:%0d over=%0d",
                 tag, cyc, x, y, p1_pos, p2_pos, p1_score, p2_score, game_over);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        // Free-running game: serve, step, p2 miss, p1 miss, p2 miss, game over.
        do_reset();
        expect_state("reset", 4, 4, 2, 2, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            #1;
            check("tick_sched", 32'(tick), (i % 4 == 3) ? 32'd1 : 32'd0);
            run_cycle();
        end
        expect_state("step1", 5, 5, 2, 2, 0, 0, 0);
        run_to(24);  expect_state("step2", 6, 6, 2, 2, 0, 0, 0);
        run_to(32);  expect_state("p2_miss", 7, 7, 2, 2, 1, 0, 0);
        run_to(40);  expect_state("reserve", 4, 4, 2, 2, 1, 0, 0);
        run_to(56);  expect_state("serve_left", 3, 5, 2, 2, 1, 0, 0);
        run_to(80);  expect_state("p1_miss", 0, 6, 2, 2, 1, 1, 0);
        run_to(88);  expect_state("reserve2", 4, 4, 2, 2, 1, 1, 0);
        run_to(120); expect_state("p2_miss2", 7, 7, 2, 2, 2, 1, 0);
        run_to(128); expect_state("game_over", 7, 7, 2, 2, 2, 1, 1);
        p1_up = 1'b1; p2_down = 1'b1;
        run_to(148); expect_state("over_frozen", 7, 7, 2, 2, 2, 1, 1);
        p1_up = 1'b0; p2_down = 1'b0;
        do_reset();
        expect_state("over_reset", 4, 4, 2, 2, 0, 0, 0);

        // p2 holds down: paddle saturates low, returns the ball, then top/bottom bounce.
        do_reset();
        p2_down = 1'b1;
        run_to(12);  expect_state("p2_sat", 4, 4, 2, 5, 0, 0, 0);
        run_to(24);  expect_state("approach", 6, 6, 2, 5, 0, 0, 0);
        run_to(32);  expect_state("p2_hit", 5, 7, 2, 5, 0, 0, 0);
        run_to(40);  expect_state("wall", 4, 6, 2, 5, 0, 0, 0);
        p2_down = 1'b0;

        // p1 saturates at the top; p2 pressing both buttons stays put.
        do_reset();
        p1_up = 1'b1; p2_up = 1'b1; p2_down = 1'b1;
        run_to(12);  expect_state("pad_limits", 4, 4, 0, 2, 0, 0, 0);
        p1_up = 1'b0; p2_up = 1'b0; p2_down = 1'b0;

        // Pause mid-play freezes the tick and every output, including paddle inputs.
        do_reset();
        run_to(20);  expect_state("pre_pause", 5, 5, 2, 2, 0, 0, 0);
        pause = 1'b1; p1_down = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("pause_tick", 32'(tick), 32'd0);
            run_cycle();
        end
        expect_state("paused", 5, 5, 2, 2, 0, 0, 0);
        pause = 1'b0; p1_down = 1'b0;
        run_to(44);  expect_state("resumed", 6, 6, 2, 2, 0, 0, 0);

        // Reset during POINT restores everything on the next edge.
        do_reset();
        run_to(34);  expect_state("in_point", 7, 7, 2, 2, 1, 0, 0);
        reset = 1'b1;
        run_cycle();
        expect_state("point_reset", 4, 4, 2, 2, 0, 0, 0);
        reset = 1'b0;
        cyc = 0;
        run_to(16);  expect_state("restart", 5, 5, 2, 2, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
